// File: rtl/pwm_hbridge_driver_pkg.sv
// Shared types, widths and defaults for the H-bridge PWM driver.
// Duty magnitude/sign helpers used at the period latch.
package pwm_hbridge_driver_pkg;

  localparam int DUTY_W       = 24;
  localparam int DEF_PERIOD   = 2500;
  localparam int DEF_DEADTIME = 8;
  localparam int DEF_CNT_W    = 24;

  localparam logic [DUTY_W-1:0] DUTY_MIN =
    {1'b1, {(DUTY_W-1){1'b0}}};
  localparam logic [DUTY_W-1:0] DUTY_MAX =
    {1'b0, {(DUTY_W-1){1'b1}}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FWD    = 2'd1,
    ST_REV    = 2'd2,
    ST_SWITCH = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    LEG_OFF = 2'd0,
    LEG_MOD = 2'd1,
    LEG_LOW = 2'd2
  } leg_mode_t;

  typedef enum logic [1:0] {
    SGN_ZERO = 2'd0,
    SGN_POS  = 2'd1,
    SGN_NEG  = 2'd2
  } sign_t;

  // Most negative duty has no positive twin; clamp it.
  function automatic logic [DUTY_W-1:0] sat_mag(
    input logic signed [DUTY_W-1:0] d
  );
    logic [DUTY_W-1:0] m;
    if (d == DUTY_MIN)
      m = DUTY_MAX;
    else if (d[DUTY_W-1])
      m = -d;
    else
      m = d;
    return m;
  endfunction

  function automatic sign_t duty_sign(
    input logic signed [DUTY_W-1:0] d
  );
    sign_t s;
    if (d == '0)
      s = SGN_ZERO;
    else if (d[DUTY_W-1])
      s = SGN_NEG;
    else
      s = SGN_POS;
    return s;
  endfunction

endpackage

// File: rtl/pwm_hbridge_driver_leg.sv
// One half-bridge: registered hi/lo gates from counter vs compare,
// with dead time inserted around every modulated transition.
module pwm_leg
  import pwm_hbridge_driver_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PERIOD   = DEF_PERIOD,
  parameter int DEADTIME = DEF_DEADTIME
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] cmp,
  input  leg_mode_t        mode,
  output logic             hi,
  output logic             lo
);

  localparam logic [CNT_W:0] DT_X  = (CNT_W+1)'(DEADTIME);
  localparam logic [CNT_W:0] PER_X = (CNT_W+1)'(PERIOD);

  logic [CNT_W:0] cnt_x;
  logic [CNT_W:0] cmp_x;
  logic           hi_d;
  logic           lo_d;

  // One spare bit so cmp+DEADTIME cannot wrap.
  assign cnt_x = {1'b0, cnt};
  assign cmp_x = {1'b0, cmp};

  always_comb begin
    hi_d = 1'b0;
    lo_d = 1'b0;
    unique case (mode)
      LEG_MOD: begin
        hi_d = (cnt_x >= DT_X) && (cnt_x < cmp_x);
        lo_d = (cnt_x >= cmp_x + DT_X) &&
               (cmp_x < PER_X);
      end
      LEG_LOW: lo_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      hi <= 1'b0;
      lo <= 1'b0;
    end else begin
      hi <= hi_d;
      lo <= lo_d;
    end
  end

endmodule

// File: rtl/pwm_hbridge_driver.sv
// Full H-bridge PWM driver fed by the signed PID duty word.
// Define PWM_BRAKE_EN to hold both low sides on while IDLE and enabled.
module pwm_hbridge_driver
  import pwm_hbridge_driver_pkg::*;
#(
  parameter int PERIOD   = DEF_PERIOD,
  parameter int DEADTIME = DEF_DEADTIME,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic                     CLK,
  input  logic                     reset,
  input  logic                     enable,
  input  logic signed [DUTY_W-1:0] duty,
  output logic                     a_hi,
  output logic                     a_lo,
  output logic                     b_hi,
  output logic                     b_lo,
  output logic                     period_start,
  output logic [1:0]               direction
);

  localparam logic [CNT_W-1:0] LAST  = CNT_W'(PERIOD-1);
  localparam logic [CNT_W:0]   PER_X = (CNT_W+1)'(PERIOD);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cmp;
  logic [CNT_W:0]   mag_x;
  logic             latch;
  logic             brake_on;
  sign_t            sgn;
  state_t           state_q;
  state_t           state_d;
  leg_mode_t        mode_a;
  leg_mode_t        mode_b;

  assign latch = (cnt == LAST);
  assign sgn   = duty_sign(duty);
  assign mag_x = (CNT_W+1)'(sat_mag(duty));

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt          <= '0;
      cmp          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= latch ? '0 : cnt + CNT_W'(1);
      period_start <= latch;
      if (latch)
        cmp <= (mag_x > PER_X) ? PER_X[CNT_W-1:0]
                               : mag_x[CNT_W-1:0];
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Any sign flip while driving costs one all-off period.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (latch) begin
      unique case (1'b1)
        sgn == SGN_POS:
          state_d = (state_q == ST_REV) ? ST_SWITCH : ST_FWD;
        sgn == SGN_NEG:
          state_d = (state_q == ST_FWD) ? ST_SWITCH : ST_REV;
        default:
          state_d = ST_IDLE;
      endcase
    end
  end

`ifdef PWM_BRAKE_EN
  localparam int GW = $clog2(DEADTIME + 1) + 1;

  logic [GW-1:0] guard;
  logic          brake_act;

  assign brake_act = enable && (state_q == ST_IDLE);

  // Brake lows wait DEADTIME cycles after any other gate pattern.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset)
      guard <= GW'(DEADTIME);
    else if (!brake_act)
      guard <= GW'(DEADTIME);
    else if (guard != '0)
      guard <= guard - GW'(1);
  end

  assign brake_on = brake_act && (guard == '0);
`else
  assign brake_on = 1'b0;
`endif

  always_comb begin
    mode_a = LEG_OFF;
    mode_b = LEG_OFF;
    if (enable) begin
      unique case (state_q)
        ST_FWD: begin
          mode_a = LEG_MOD;
          mode_b = LEG_LOW;
        end
        ST_REV: begin
          mode_a = LEG_LOW;
          mode_b = LEG_MOD;
        end
        ST_IDLE: begin
          if (brake_on) begin
            mode_a = LEG_LOW;
            mode_b = LEG_LOW;
          end
        end
        default: ;
      endcase
    end
  end

  pwm_leg #(
    .CNT_W   (CNT_W),
    .PERIOD  (PERIOD),
    .DEADTIME(DEADTIME)
  ) u_leg_a (
    .CLK  (CLK),
    .reset(reset),
    .cnt  (cnt),
    .cmp  (cmp),
    .mode (mode_a),
    .hi   (a_hi),
    .lo   (a_lo)
  );

  pwm_leg #(
    .CNT_W   (CNT_W),
    .PERIOD  (PERIOD),
    .DEADTIME(DEADTIME)
  ) u_leg_b (
    .CLK  (CLK),
    .reset(reset),
    .cnt  (cnt),
    .cmp  (cmp),
    .mode (mode_b),
    .hi   (b_hi),
    .lo   (b_lo)
  );

  assign direction = state_q;

endmodule

// File: tb/tb_pwm_hbridge_driver.sv
// Bench for pwm_hbridge_driver at PERIOD=100, DEADTIME=4.
// Reference model follows the gating rules with plain integer arithmetic.
module tb_pwm_hbridge_driver;

  localparam int PERIOD = 100;
  localparam int DT     = 4;

  logic              CLK = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic signed [23:0] duty = '0;
  logic              a_hi, a_lo, b_hi, b_lo;
  logic              period_start;
  logic [1:0]        direction;

  int n_chk = 0;
  int n_fail = 0;

  always #5 CLK = ~CLK;

  pwm_hbridge_driver #(
    .PERIOD  (PERIOD),
    .DEADTIME(DT),
    .CNT_W   (24)
  ) dut (
    .CLK         (CLK),
    .reset       (reset),
    .enable      (enable),
    .duty        (duty),
    .a_hi        (a_hi),
    .a_lo        (a_lo),
    .b_hi        (b_hi),
    .b_lo        (b_lo),
    .period_start(period_start),
    .direction   (direction)
  );

  // next state indexed [state][sign: 0 zero, 1 pos, 2 neg]
  int nxt [0:3][0:2] = '{'{0, 1, 2}, '{0, 1, 3},
                         '{0, 3, 2}, '{0, 1, 2}};

  int         m_cnt = 0, m_cmp = 0, m_st = 0, m_run = 0;
  logic [3:0] m_g = '0;
  logic       m_ps = 1'b0;
  int         md, mmag, msg;
  logic       mwrap;

  function automatic logic [1:0] leg(int c, int cmp);
    return {(c >= DT) && (c < cmp),
            (c >= cmp + DT) && (cmp < PERIOD)};
  endfunction

  function automatic logic [3:0] gates(int c, int cmp, int st,
                                       logic en, int run);
    logic brk;
`ifdef PWM_BRAKE_EN
    brk = (run >= DT);
`else
    brk = 1'b0;
`endif
    if (!en) return 4'b0000;
    case (st)
      1: return {leg(c, cmp), 2'b01};
      2: return {2'b01, leg(c, cmp)};
      0: return brk ? 4'b0101 : 4'b0000;
      default: return 4'b0000;
    endcase
  endfunction

  always @(posedge CLK or negedge reset) begin
    if (!reset) begin
      m_cnt = 0; m_cmp = 0; m_st = 0; m_run = 0;
      m_g = '0; m_ps = 1'b0;
    end else begin
      mwrap = (m_cnt == PERIOD - 1);
      m_g  = gates(m_cnt, m_cmp, m_st, enable, m_run);
      m_ps = mwrap;
      m_run = (m_st == 0 && enable) ? m_run + 1 : 0;
      if (mwrap) begin
        md = duty;
        if (md == -8388608) mmag = 8388607;
        else mmag = (md < 0) ? -md : md;
        m_cmp = (mmag > PERIOD) ? PERIOD : mmag;
        msg = (md > 0) ? 1 : (md < 0) ? 2 : 0;
      end
      if (!enable) m_st = 0;
      else if (mwrap) m_st = nxt[m_st][msg];
      m_cnt = mwrap ? 0 : m_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_ps();
    int k = 0;
    do begin
      tick();
      k++;
    end while (period_start !== 1'b1 && k < 250);
    n_chk++;
    if (period_start !== 1'b1) begin
      n_fail++;
      $display("FAIL wait_ps: period_start=%b, required 1 within 250 cycles",
               period_start);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b1; duty = 24'sd50;
    repeat (3) tick();
    reset = 1'b1;
    repeat (150) tick();
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({a_hi, a_lo, b_hi, b_lo} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_gates: got %b, required 0000",
               {a_hi, a_lo, b_hi, b_lo});
    end
    n_chk++;
    if (direction !== 2'd0 || period_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: dir=%0d ps=%b, required dir=0 ps=0",
               direction, period_start);
    end
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      n_chk++;
      if (direction !== ((k < 100) ? 2'd0 : 2'd1) ||
          period_start !== (k == 100)) begin
        n_fail++;
        $display("FAIL reset_release k=%0d: dir=%0d ps=%b, required dir=%0d ps=%b",
                 k, direction, period_start, (k < 100) ? 0 : 1, k == 100);
      end
      n_chk++;
      if ({a_hi, a_lo, b_hi, b_lo} !== m_g || period_start !== m_ps ||
          direction !== 2'(m_st)) begin
        n_fail++;
        $display("FAIL model_reset k=%0d: g=%b ps=%b dir=%0d, required g=%b ps=%b dir=%0d",
                 k, {a_hi, a_lo, b_hi, b_lo}, period_start, direction,
                 m_g, m_ps, m_st);
      end
    end
  endtask

  task automatic test_fwd();
    int nah = 0, nal = 0, nbh = 0, nbl = 0;
    wait_ps();
    for (int k = 1; k <= 100; k++) begin
      tick();
      nah += int'(a_hi); nal += int'(a_lo);
      nbh += int'(b_hi); nbl += int'(b_lo);
      n_chk++;
      if ({a_hi, a_lo, b_hi, b_lo} !== m_g || direction !== 2'(m_st)) begin
        n_fail++;
        $display("FAIL model_fwd k=%0d: g=%b dir=%0d, required g=%b dir=%0d",
                 k, {a_hi, a_lo, b_hi, b_lo}, direction, m_g, m_st);
      end
    end
    n_chk++;
    if (nah != 46 || nal != 46 || nbh != 0 || nbl != 100) begin
      n_fail++;
      $display("FAIL fwd_counts: a_hi=%0d a_lo=%0d b_hi=%0d b_lo=%0d, required 46 46 0 100",
               nah, nal, nbh, nbl);
    end
  endtask

  task automatic test_reverse();
    int nsw = 0, nbh = 0, nal = 0;
    wait_ps();
    duty = -24'sd30;
    for (int k = 1; k <= 300; k++) begin
      tick();
      nsw += int'(direction == 2'd3);
      nbh += int'(b_hi);
      if (k > 200) nal += int'(a_lo);
      n_chk++;
      if ((a_hi & a_lo) | (b_hi & b_lo)) begin
        n_fail++;
        $display("FAIL rev_overlap k=%0d: g=%b, required no leg overlap",
                 k, {a_hi, a_lo, b_hi, b_lo});
      end
    end
    n_chk++;
    if (nsw != 100) begin
      n_fail++;
      $display("FAIL rev_switch_len: got %0d, required 100", nsw);
    end
    n_chk++;
    if (nbh != 26 || nal != 100) begin
      n_fail++;
      $display("FAIL rev_counts: b_hi=%0d a_lo=%0d, required 26 100",
               nbh, nal);
    end
  endtask

  task automatic test_clip();
    int nbh = 0, nbl = 0, nal = 0, nah = 0, nsw = 0, nbl2 = 0;
    wait_ps();
    duty = 24'h800000;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k > 100) begin
        nbh += int'(b_hi); nbl += int'(b_lo); nal += int'(a_lo);
      end
    end
    n_chk++;
    if (nbh != 96 || nbl != 0 || nal != 100) begin
      n_fail++;
      $display("FAIL clip_neg: b_hi=%0d b_lo=%0d a_lo=%0d, required 96 0 100",
               nbh, nbl, nal);
    end
    wait_ps();
    duty = 24'sd500;
    nal = 0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      nsw += int'(direction == 2'd3);
      if (k > 200) begin
        nah += int'(a_hi); nal += int'(a_lo); nbl2 += int'(b_lo);
      end
    end
    n_chk++;
    if (nsw != 100 || nah != 96 || nal != 0 || nbl2 != 100) begin
      n_fail++;
      $display("FAIL clip_pos: sw=%0d a_hi=%0d a_lo=%0d b_lo=%0d, required 100 96 0 100",
               nsw, nah, nal, nbl2);
    end
  endtask

  task automatic test_small();
    int nah = 0, nal = 0, nps = 0;
    wait_ps();
    duty = 24'sd3;
    for (int k = 1; k <= 200; k++) begin
      tick();
      nps += int'(period_start);
      if (k > 100) begin
        nah += int'(a_hi); nal += int'(a_lo);
      end
    end
    n_chk++;
    if (nah != 0 || nal != 93) begin
      n_fail++;
      $display("FAIL small_duty: a_hi=%0d a_lo=%0d, required 0 93", nah, nal);
    end
    n_chk++;
    if (nps != 2) begin
      n_fail++;
      $display("FAIL ps_rate: got %0d pulses in 200 cycles, required 2", nps);
    end
  endtask

  task automatic test_enable();
    logic [3:0] g;
    wait_ps();
    duty = 24'sd100;
    wait_ps();
    repeat (50) tick();
    enable = 1'b0;
    tick();
    n_chk++;
    if ({a_hi, a_lo, b_hi, b_lo} !== 4'b0000 || direction !== 2'd0) begin
      n_fail++;
      $display("FAIL enable_drop: g=%b dir=%0d, required g=0000 dir=0",
               {a_hi, a_lo, b_hi, b_lo}, direction);
    end
    repeat (10) tick();
    duty = 24'sd0;
    enable = 1'b1;
    for (int k = 1; k <= 250; k++) begin
      tick();
      g = {a_hi, a_lo, b_hi, b_lo};
      n_chk++;
      if (g !== m_g || direction !== 2'(m_st)) begin
        n_fail++;
        $display("FAIL model_enable k=%0d: g=%b dir=%0d, required g=%b dir=%0d",
                 k, g, direction, m_g, m_st);
      end
      if (k == 4 || k == 5) begin
        n_chk++;
`ifdef PWM_BRAKE_EN
        if (g !== ((k == 5) ? 4'b0101 : 4'b0000)) begin
`else
        if (g !== 4'b0000) begin
`endif
          n_fail++;
          $display("FAIL idle_gates k=%0d: got %b", k, g);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] g, gp;
    int off_run [4];
    int drop_at, drop_len, v;
    wait_ps();
    gp = {a_hi, a_lo, b_hi, b_lo};
    for (int i = 0; i < 4; i++) off_run[i] = gp[i] ? 0 : DT;
    for (int p = 0; p < 30; p++) begin
      v = int'($urandom_range(1, 150));
      case ($urandom_range(0, 7))
        0: duty = 24'sd0;
        1: duty = 24'($urandom_range(1, 8));
        2: duty = 24'(-int'($urandom_range(1, 8)));
        3: duty = 24'(v);
        4: duty = 24'(-v);
        5: duty = 24'h800000;
        6: duty = 24'h7FFFFF;
        default: duty = 24'($urandom);
      endcase
      drop_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 60)) : -1;
      drop_len = int'($urandom_range(1, 20));
      for (int k = 1; k <= 100; k++) begin
        if (k == drop_at) enable = 1'b0;
        if (k == drop_at + drop_len) enable = 1'b1;
        tick();
        g = {a_hi, a_lo, b_hi, b_lo};
        n_chk++;
        if (g !== m_g || period_start !== m_ps || direction !== 2'(m_st)) begin
          n_fail++;
          $display("FAIL model_rand p=%0d k=%0d duty=%0d: g=%b ps=%b dir=%0d, required g=%b ps=%b dir=%0d",
                   p, k, duty, g, period_start, direction, m_g, m_ps, m_st);
        end
        n_chk++;
        if ((g[3] & g[2]) | (g[1] & g[0])) begin
          n_fail++;
          $display("FAIL overlap p=%0d k=%0d: g=%b, required no leg overlap",
                   p, k, g);
        end
        for (int i = 0; i < 4; i++) begin
          if (g[i] && !gp[i]) begin
            n_chk++;
            if (off_run[i ^ 1] < DT) begin
              n_fail++;
              $display("FAIL deadtime p=%0d k=%0d sw=%0d: comp off %0d cycles, required >= %0d",
                       p, k, i, off_run[i ^ 1], DT);
            end
          end
        end
        for (int i = 0; i < 4; i++)
          off_run[i] = g[i] ? 0 : off_run[i] + 1;
        gp = g;
      end
    end
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_reverse();
    test_clip();
    test_small();
    test_enable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
